acc_cpu_core: RTL and testbench
===============================

Name: acc_cpu_core

Overview:
- Parametrised successor of the single-accumulator controller.
- Instruction ROM moves out of the block: instructions come from an external memory port.
- The data bus gains a request/ack handshake with arbitrary wait states.
- Adds explicit halt state, synchronous reset, and a retire strobe.
- Sits between program memory and the shared data bus; the system wrapper instantiates one core per program.

Parameters:
- DATA_W, 32: accumulator and data bus width; power of two, 8..64.
- PC_W, 6: program counter width; 1..8.
- ADDR_W, 8: data bus address width; 1..8; taken from instr[ADDR_W-1:0].
- STACK_DEPTH, 4: return stack entries; only used with CALL_STACK_EN.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  synchronous active-high reset.
- imem_addr  out  PC_W  program address; equals pc.
- imem_data  in  16  instruction at imem_addr, combinational, same cycle.
- bus_addr  out  ADDR_W  data address, registered.
- bus_rd  out  1  read request, registered.
- bus_wr  out  1  write request, registered.
- bus_wdata  out  DATA_W  write data, registered.
- bus_rdata  in  DATA_W  read data; valid when bus_ack=1.
- bus_ack  in  1  completes the outstanding request.
- acc  out  DATA_W  accumulator.
- pc  out  PC_W  program counter.
- retire  out  1  one-cycle pulse per completed instruction.
- halted  out  1  core stopped.

Behaviour:
- Clock and reset: one clock, CLK; RST is synchronous and active-high.
- Reset values: pc=0, acc=0, state=EXEC, bus_rd=bus_wr=0, bus_addr=0, bus_wdata=0, retire=0, halted=0. RST wins over every other event, including mid-wait.
- Instruction format: opcode=instr[15:8], operand=instr[7:0].
  - Immediates are zero-extended to DATA_W.
  - Shift amount is instr[log2(DATA_W)-1:0].
  - All arithmetic is modulo 2^DATA_W.
  - pc+1 wraps modulo 2^PC_W.
  - Branch target is instr[PC_W-1:0].
- Opcodes:
  - 00 NOP
  - 01 ADD[m]; 02 ADDI
  - 03 SUB[m]; 04 SUBI
  - 05 SHL; 06 SHR (logical)
  - 07 LD[m]; 08 LDI
  - 09 ST[m]
  - 0A AND[m]; 0B ANDI
  - 0C OR[m]; 0D ORI
  - 0E XOR[m]; 0F XORI
  - 10 BR; 11 BRZ (acc==0); 12 BRNZ
  - 13 EXIT
  - 14 CALL; 15 RET (optional feature)
  - All other opcodes execute as NOP.
- FSM states: EXEC, WAIT_RD, WAIT_WR, HALT.
- EXEC, non-memory op: decode imem_data, update acc/pc at the next edge, retire=1 for that cycle. Latency is 1 cycle.
- EXEC, read op (m, or LD):
  - Latch opcode; set bus_addr=operand and bus_rd=1; go to WAIT_RD.
  - pc and acc are unchanged.
- EXEC, ST:
  - Set bus_addr, bus_wdata=acc, bus_wr=1; go to WAIT_WR.
- WAIT_RD / WAIT_WR:
  - bus_addr, bus_rd/bus_wr and bus_wdata are held stable until bus_ack is sampled high.
  - On the ack edge: clear the request; apply acc=op(acc, bus_rdata) for reads (acc unchanged for ST); pc=pc+1; retire=1; return to EXEC.
  - Minimum memory latency is 2 cycles (ack in the first wait cycle).
  - bus_ack outside WAIT states is ignored.
- EXIT: retire=1; halted=1; go to HALT. pc is not advanced.
- HALT: all state is frozen and no bus requests are issued. Only RST leaves HALT.
- retire is registered, asserted exactly in the cycle after the updating edge, and never asserted twice for one instruction.

Optional Feature:
- Macro: CALL_STACK_EN.
- Defined:
  - Adds a STACK_DEPTH x PC_W return stack with an occupancy counter.
  - CALL pushes pc+1 (wrapped) and jumps to the target.
  - RET pops into pc.
  - CALL when full, or RET when empty, behaves as EXIT but with no retire pulse: halted=1, pc holds at the faulting instruction.
  - Reset empties the stack.
- Undefined: 14/15 execute as NOP and no stack storage exists.

Test Plan:
- Program LDI 5; ADDI 3; SHL 2; EXIT -> acc=32, pc=3, 4 retire pulses, halted=1 from cycle 5, then frozen for 10 cycles.
- acc=10, ADD 0x20, bus_ack delayed 3 cycles with bus_rdata=7 -> bus_rd=1 and bus_addr=0x20 stable for 3 cycles, acc=17 after ack, single retire.
- LDI 0xEF; ST 0x40; ack in the first wait cycle -> bus_wr=1, bus_wdata=0xEF, bus_addr=0x40 for exactly 1 cycle, acc unchanged, 2-cycle instruction.
- BRZ 9 with acc=0 -> pc=9; BRNZ 9 with acc=0 -> pc+1; NOP at pc=63 with PC_W=6 -> pc=0.
- RST asserted during WAIT_RD with no ack -> bus_rd=0, pc=0, acc=0 after that edge; a later stray bus_ack has no effect.
- With CALL_STACK_EN and STACK_DEPTH=2:
  - CALL, CALL, RET, RET returns to the correct addresses.
  - A third nested CALL -> halted=1, no retire.
  - Without the macro, CALL acts as NOP.

Source files
------------

// File: rtl/acc_cpu_core.sv
// acc_cpu_core -- single-accumulator controller core.
//
// Fetches 16-bit instructions from an external program memory (combinational
// read at imem_addr == pc) and talks to a shared data bus through a
// request/ack handshake that tolerates any number of wait states.
//
// Optional feature macro: CALL_STACK_EN
//   defined   : CALL (0x14) / RET (0x15) use a STACK_DEPTH x PC_W return stack;
//               overflow/underflow stops the core without a retire pulse.
//   undefined : 0x14 / 0x15 execute as NOP and no stack storage exists.
//
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   imem_addr/data    program address (== pc) / instruction at that address
//   bus_addr/rd/wr    registered data-bus request, held until bus_ack
//   bus_wdata         registered store data (accumulator at ST issue)
//   bus_rdata/ack     read data and request completion
//   acc, pc           architectural state
//   retire            one-cycle pulse per completed instruction
//   halted            core stopped (EXIT or stack fault); only RST clears it
module acc_cpu_core #(
   parameter int DATA_W      = 32,
   parameter int PC_W        = 6,
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic              CLK,
   input  logic              RST,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_data,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_rd,
   output logic              bus_wr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic [DATA_W-1:0] bus_rdata,
   input  logic              bus_ack,
   output logic [DATA_W-1:0] acc,
   output logic [PC_W-1:0]   pc,
   output logic              retire,
   output logic              halted
);

   localparam int SH_W = $clog2(DATA_W);

   if ((DATA_W < 8) || (DATA_W > 64) || ((DATA_W & (DATA_W - 1)) != 0) ||
       (PC_W < 1) || (PC_W > 8) || (ADDR_W < 1) || (ADDR_W > 8) ||
       (STACK_DEPTH < 1)) begin : g_param_check
      $error("acc_cpu_core: parameter out of range");
   end

   localparam logic [7:0] OP_ADD  = 8'h01, OP_ADDI = 8'h02;
   localparam logic [7:0] OP_SUB  = 8'h03, OP_SUBI = 8'h04;
   localparam logic [7:0] OP_SHL  = 8'h05, OP_SHR  = 8'h06;
   localparam logic [7:0] OP_LD   = 8'h07, OP_LDI  = 8'h08;
   localparam logic [7:0] OP_ST   = 8'h09;
   localparam logic [7:0] OP_AND  = 8'h0A, OP_ANDI = 8'h0B;
   localparam logic [7:0] OP_OR   = 8'h0C, OP_ORI  = 8'h0D;
   localparam logic [7:0] OP_XOR  = 8'h0E, OP_XORI = 8'h0F;
   localparam logic [7:0] OP_BR   = 8'h10, OP_BRZ  = 8'h11, OP_BRNZ = 8'h12;
   localparam logic [7:0] OP_EXIT = 8'h13;
`ifdef CALL_STACK_EN
   localparam logic [7:0] OP_CALL = 8'h14, OP_RET  = 8'h15;
`endif

   typedef enum logic [1:0] {S_EXEC, S_WAIT_RD, S_WAIT_WR, S_HALT} state_t;

   // Shared by immediate forms (b = operand) and memory forms (b = bus_rdata).
   function automatic logic [DATA_W-1:0] alu(input logic [7:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
      case (op)
         OP_ADD, OP_ADDI: alu = a + b;
         OP_SUB, OP_SUBI: alu = a - b;
         OP_LD,  OP_LDI:  alu = b;
         OP_AND, OP_ANDI: alu = a & b;
         OP_OR,  OP_ORI:  alu = a | b;
         OP_XOR, OP_XORI: alu = a ^ b;
         default:         alu = a;
      endcase
   endfunction

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic [7:0]          op_q, op_d;
   logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
   logic                bus_rd_q, bus_rd_d;
   logic                bus_wr_q, bus_wr_d;
   logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
   logic                retire_q, retire_d;
   logic                halted_q, halted_d;

   logic [7:0]          opcode;
   logic [DATA_W-1:0]   imm;
   logic [SH_W-1:0]     shamt;
   logic [PC_W-1:0]     target;
   logic [PC_W-1:0]     pc_inc;

   assign opcode = imem_data[15:8];
   assign imm    = DATA_W'(imem_data[7:0]);
   assign shamt  = imem_data[SH_W-1:0];
   assign target = imem_data[PC_W-1:0];
   assign pc_inc = pc_q + PC_W'(1);

`ifdef CALL_STACK_EN
   localparam int SP_W  = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [PC_W-1:0] stack_q [STACK_DEPTH];
   logic [SP_W-1:0] sp_q, sp_d;
   logic            push_en;
`endif

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      acc_d       = acc_q;
      op_d        = op_q;
      bus_addr_d  = bus_addr_q;
      bus_rd_d    = bus_rd_q;
      bus_wr_d    = bus_wr_q;
      bus_wdata_d = bus_wdata_q;
      retire_d    = 1'b0;
      halted_d    = halted_q;
`ifdef CALL_STACK_EN
      sp_d        = sp_q;
      push_en     = 1'b0;
`endif
      case (state_q)
         S_EXEC: begin
            // Single-cycle ops retire at the next edge; the few cases that
            // wait on the bus or stop the core override these.
            retire_d = 1'b1;
            pc_d     = pc_inc;
            case (opcode)
               OP_ADDI, OP_SUBI, OP_LDI, OP_ANDI, OP_ORI, OP_XORI:
                  acc_d = alu(opcode, acc_q, imm);
               OP_ADD, OP_SUB, OP_LD, OP_AND, OP_OR, OP_XOR: begin
                  op_d       = opcode;
                  bus_addr_d = imem_data[ADDR_W-1:0];
                  bus_rd_d   = 1'b1;
                  state_d    = S_WAIT_RD;
                  retire_d   = 1'b0;
                  pc_d       = pc_q;
               end
               OP_ST: begin
                  bus_addr_d  = imem_data[ADDR_W-1:0];
                  bus_wdata_d = acc_q;
                  bus_wr_d    = 1'b1;
                  state_d     = S_WAIT_WR;
                  retire_d    = 1'b0;
                  pc_d        = pc_q;
               end
               OP_SHL:  acc_d = acc_q << shamt;
               OP_SHR:  acc_d = acc_q >> shamt;
               OP_BR:   pc_d = target;
               OP_BRZ:  if (acc_q == '0) pc_d = target;
               OP_BRNZ: if (acc_q != '0) pc_d = target;
               OP_EXIT: begin
                  pc_d     = pc_q;
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
`ifdef CALL_STACK_EN
               // Stack faults stop the core at the faulting instruction
               // without a retire pulse.
               OP_CALL: begin
                  if (sp_q == SP_W'(STACK_DEPTH)) begin
                     retire_d = 1'b0;
                     pc_d     = pc_q;
                     halted_d = 1'b1;
                     state_d  = S_HALT;
                  end else begin
                     push_en = 1'b1;
                     sp_d    = sp_q + SP_W'(1);
                     pc_d    = target;
                  end
               end
               OP_RET: begin
                  if (sp_q == '0) begin
                     retire_d = 1'b0;
                     pc_d     = pc_q;
                     halted_d = 1'b1;
                     state_d  = S_HALT;
                  end else begin
                     sp_d = sp_q - SP_W'(1);
                     pc_d = stack_q[IDX_W'(sp_q - SP_W'(1))];
                  end
               end
`endif
               default: ;
            endcase
         end
         S_WAIT_RD: begin
            if (bus_ack) begin
               acc_d    = alu(op_q, acc_q, bus_rdata);
               bus_rd_d = 1'b0;
               pc_d     = pc_inc;
               retire_d = 1'b1;
               state_d  = S_EXEC;
            end
         end
         S_WAIT_WR: begin
            if (bus_ack) begin
               bus_wr_d = 1'b0;
               pc_d     = pc_inc;
               retire_d = 1'b1;
               state_d  = S_EXEC;
            end
         end
         S_HALT: ;
         default: state_d = S_EXEC;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= S_EXEC;
         pc_q        <= '0;
         acc_q       <= '0;
         op_q        <= '0;
         bus_addr_q  <= '0;
         bus_rd_q    <= 1'b0;
         bus_wr_q    <= 1'b0;
         bus_wdata_q <= '0;
         retire_q    <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         acc_q       <= acc_d;
         op_q        <= op_d;
         bus_addr_q  <= bus_addr_d;
         bus_rd_q    <= bus_rd_d;
         bus_wr_q    <= bus_wr_d;
         bus_wdata_q <= bus_wdata_d;
         retire_q    <= retire_d;
         halted_q    <= halted_d;
      end
   end

`ifdef CALL_STACK_EN
   // Entries above the occupancy counter are dead, so only sp needs reset.
   always_ff @(posedge CLK) begin
      if (RST) sp_q <= '0;
      else     sp_q <= sp_d;
   end

   always_ff @(posedge CLK) begin
      if (!RST && push_en) stack_q[IDX_W'(sp_q)] <= pc_inc;
   end
`endif

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign acc       = acc_q;
   assign bus_addr  = bus_addr_q;
   assign bus_rd    = bus_rd_q;
   assign bus_wr    = bus_wr_q;
   assign bus_wdata = bus_wdata_q;
   assign retire    = retire_q;
   assign halted    = halted_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
module tb_acc_cpu_core;
   localparam int DATA_W = 32;
   localparam int PC_W   = 6;
   localparam int ADDR_W = 8;
`ifdef CALL_STACK_EN
   localparam int STACK_DEPTH = 2;
`else
   localparam int STACK_DEPTH = 4;
`endif

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic [PC_W-1:0]   imem_addr;
   logic [15:0]       imem_data;
   logic [ADDR_W-1:0] bus_addr;
   logic              bus_rd, bus_wr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata = '0;
   logic              bus_ack = 1'b0;
   logic [DATA_W-1:0] acc;
   logic [PC_W-1:0]   pc;
   logic              retire, halted;

   acc_cpu_core #(.DATA_W(DATA_W), .PC_W(PC_W), .ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) dut (
      .CLK(CLK), .RST(RST), .imem_addr(imem_addr), .imem_data(imem_data),
      .bus_addr(bus_addr), .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .bus_ack(bus_ack), .acc(acc), .pc(pc),
      .retire(retire), .halted(halted)
   );

   always #5 CLK = ~CLK;

   logic [15:0] prog [64];
   assign imem_data = prog[imem_addr];

   logic [31:0] dmem [256];   // memory seen by the bus responder
   logic [31:0] mmem [256];   // reference model's own copy

   // Reference model: instruction-level machine state.
   logic [31:0] macc;
   logic [5:0]  mpc;
   bit          mhalt;

   int checks = 0;
   int errors = 0;
   int retire_cnt, req_cycles, halt_cycle, cyc, wcnt;
   bit in_req, stray_en;
   logic [ADDR_W-1:0] s_addr;
   logic s_rd, s_wr;
   logic [31:0] s_wdata;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_read(input logic [7:0] op);
      return op inside {8'h01, 8'h03, 8'h07, 8'h0A, 8'h0C, 8'h0E};
   endfunction

   task automatic model_step();
      logic [15:0] ins;
      logic [7:0]  op, opd;
      logic [31:0] imm, m;
      ins = prog[mpc];
      op  = ins[15:8];
      opd = ins[7:0];
      imm = {24'h0, opd};
      m   = mmem[opd];
      case (op)
         8'h01: macc = macc + m;
         8'h02: macc = macc + imm;
         8'h03: macc = macc - m;
         8'h04: macc = macc - imm;
         8'h05: macc = macc << opd[4:0];
         8'h06: macc = macc >> opd[4:0];
         8'h07: macc = m;
         8'h08: macc = imm;
         8'h09: mmem[opd] = macc;
         8'h0A: macc = macc & m;
         8'h0B: macc = macc & imm;
         8'h0C: macc = macc | m;
         8'h0D: macc = macc | imm;
         8'h0E: macc = macc ^ m;
         8'h0F: macc = macc ^ imm;
         default: ;
      endcase
      case (op)
         8'h10: mpc = opd[5:0];
         8'h11: mpc = (macc == 0) ? opd[5:0] : mpc + 6'd1;
         8'h12: mpc = (macc != 0) ? opd[5:0] : mpc + 6'd1;
         8'h13: mhalt = 1'b1;
         default: mpc = mpc + 6'd1;
      endcase
   endtask

   task automatic do_reset();
      @(negedge CLK);
      RST = 1'b1;
      bus_ack = 1'b0;
      @(negedge CLK);
      chk("rst_pc", pc, 0);
      chk("rst_acc", acc, 0);
      chk("rst_bus_rd", bus_rd, 0);
      chk("rst_bus_wr", bus_wr, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_bus_wdata", bus_wdata, 0);
      chk("rst_retire", retire, 0);
      chk("rst_halted", halted, 0);
      RST = 1'b0;
      macc = 0; mpc = 0; mhalt = 0; in_req = 0;
      retire_cnt = 0; req_cycles = 0; halt_cycle = -1; cyc = 0;
      foreach (dmem[i]) mmem[i] = dmem[i];
   endtask

   // Runs ncyc cycles, acting as the bus slave (wmin..wmax extra wait cycles)
   // and checking every retired instruction against the model.
   task automatic run(input int ncyc, input int wmin, input int wmax);
      int gap = 0;
      for (int i = 0; i < ncyc; i++) begin
         @(negedge CLK);
         cyc++;
         if (halted === 1'b1 && halt_cycle < 0) halt_cycle = cyc;
         if (retire === 1'b1) begin
            retire_cnt++;
            gap = 0;
            chk("retire_after_halt", mhalt, 0);
            if (!mhalt) begin
               model_step();
               chk("acc", acc, macc);
               chk("pc", pc, mpc);
               chk("halted", halted, mhalt);
            end
         end else begin
            gap++;
            if (!mhalt && gap > wmax + 2) begin
               chk("retire_gap", gap, wmax + 2);
               gap = 0;
            end
         end
         if (bus_rd === 1'b1 || bus_wr === 1'b1) begin
            req_cycles++;
            if (!in_req) begin
               in_req = 1;
               s_addr = bus_addr; s_rd = bus_rd; s_wr = bus_wr; s_wdata = bus_wdata;
               wcnt = $urandom_range(wmax, wmin);
               chk("req_addr", bus_addr, prog[mpc][7:0]);
               chk("req_is_read", bus_rd, is_read(prog[mpc][15:8]));
               chk("req_is_write", bus_wr, prog[mpc][15:8] == 8'h09);
               if (bus_wr) chk("req_wdata", bus_wdata, macc);
            end else begin
               chk("req_hold", {bus_addr, bus_rd, bus_wr, bus_wdata}, {s_addr, s_rd, s_wr, s_wdata});
            end
            if (wcnt == 0) begin
               bus_ack = 1'b1;
               bus_rdata = dmem[bus_addr];
               if (bus_wr) dmem[bus_addr] = bus_wdata;
               in_req = 0;
            end else begin
               wcnt--;
               bus_ack = 1'b0;
               bus_rdata = $urandom;
            end
         end else begin
            bus_ack = stray_en && ($urandom_range(0, 2) == 0);
            bus_rdata = $urandom;
         end
      end
      bus_ack = 1'b0;
   endtask

   task automatic clear_prog();
      foreach (prog[i]) prog[i] = 16'h0000;
   endtask

`ifdef CALL_STACK_EN
   logic [5:0] call_pc [7];
   logic       call_ret [7];
`endif

   initial begin
      clear_prog();
      foreach (dmem[i]) dmem[i] = $urandom;
      stray_en = 0;

      // LDI 5; ADDI 3; SHL 2; EXIT
      prog[0] = 16'h0805; prog[1] = 16'h0203; prog[2] = 16'h0502; prog[3] = 16'h1300;
      do_reset();
      run(6, 0, 0);
      chk("p1_acc", acc, 32);
      chk("p1_pc", pc, 3);
      chk("p1_retires", retire_cnt, 4);
      chk("p1_halt_cycle", halt_cycle, 4);
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         bus_ack = 1'b1;
         bus_rdata = $urandom;
         chk("frozen_acc", acc, 32);
         chk("frozen_pc", pc, 3);
         chk("frozen_retire", retire, 0);
         chk("frozen_halted", halted, 1);
         chk("frozen_bus", {bus_rd, bus_wr}, 0);
      end
      bus_ack = 1'b0;

      // LDI 10; ADD [0x20] with three wait cycles, mem = 7; EXIT
      clear_prog();
      prog[0] = 16'h080A; prog[1] = 16'h0120; prog[2] = 16'h1300;
      dmem[8'h20] = 32'd7;
      do_reset();
      run(9, 2, 2);
      chk("p2_acc", acc, 17);
      chk("p2_wait_cycles", req_cycles, 3);
      chk("p2_retires", retire_cnt, 3);
      chk("p2_halt_cycle", halt_cycle, 6);

      // LDI 0xEF; ST [0x40] acked in first wait cycle; EXIT
      clear_prog();
      prog[0] = 16'h08EF; prog[1] = 16'h0940; prog[2] = 16'h1300;
      dmem[8'h40] = 32'h0;
      do_reset();
      run(6, 0, 0);
      chk("p3_mem", dmem[8'h40], 32'hEF);
      chk("p3_acc", acc, 32'hEF);
      chk("p3_wait_cycles", req_cycles, 1);
      chk("p3_halt_cycle", halt_cycle, 4);

      // Branches and pc wrap
      clear_prog();
      prog[0] = 16'h1109; prog[9] = 16'h1209; prog[10] = 16'h103F; prog[63] = 16'h0000;
      do_reset();
      run(1, 0, 0); chk("brz_taken", pc, 9);
      run(1, 0, 0); chk("brnz_not_taken", pc, 10);
      run(1, 0, 0); chk("br_to_63", pc, 63);
      run(1, 0, 0); chk("pc_wrap", pc, 0);

      // Reset while waiting for a read ack, then stray acks
      clear_prog();
      prog[0] = 16'h0833; prog[1] = 16'h0120;
      do_reset();
      @(negedge CLK); chk("mid_ldi_acc", acc, 32'h33);
      @(negedge CLK); chk("mid_rd_issued", bus_rd, 1);
      chk("mid_rd_addr", bus_addr, 8'h20);
      @(negedge CLK); chk("mid_rd_held", bus_rd, 1);
      RST = 1'b1;
      @(negedge CLK);
      chk("mid_rst_bus_rd", bus_rd, 0);
      chk("mid_rst_pc", pc, 0);
      chk("mid_rst_acc", acc, 0);
      prog[0] = 16'h0000; prog[1] = 16'h0000;
      RST = 1'b0;
      bus_ack = 1'b1;
      bus_rdata = 32'h55;
      repeat (3) @(negedge CLK);
      bus_ack = 1'b0;
      chk("stray_acc", acc, 0);
      chk("stray_pc", pc, 3);
      chk("stray_bus_rd", bus_rd, 0);

`ifdef CALL_STACK_EN
      clear_prog();
      prog[0] = 16'h140A; prog[10] = 16'h1414; prog[20] = 16'h1500; prog[11] = 16'h1500;
      prog[1] = 16'h141E; prog[30] = 16'h1428; prog[40] = 16'h1432;
      call_pc  = '{6'd10, 6'd20, 6'd11, 6'd1, 6'd30, 6'd40, 6'd40};
      call_ret = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         @(negedge CLK);
         chk("call_pc", pc, call_pc[i]);
         chk("call_retire", retire, call_ret[i]);
      end
      chk("call_overflow_halted", halted, 1);
      @(negedge CLK);
      chk("call_overflow_no_retire", retire, 0);
      chk("call_overflow_pc", pc, 40);
`else
      clear_prog();
      prog[0] = 16'h1405; prog[1] = 16'h1300;
      do_reset();
      run(3, 0, 0);
      chk("call_as_nop_pc", pc, 1);
      chk("call_as_nop_halted", halted, 1);
      chk("call_as_nop_retires", retire_cnt, 2);
`endif

      // Randomized programs with random wait states and stray acks
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 64; i++) begin
            int k;
            logic [7:0] op;
            k = $urandom_range(0, 39);
            if (k < 19) op = 8'(k);
            else if (k == 19) op = 8'h13;
            else if (k < 38) begin
               case ($urandom_range(0, 8))
                  0: op = 8'h01; 1: op = 8'h02; 2: op = 8'h03; 3: op = 8'h07;
                  4: op = 8'h08; 5: op = 8'h09; 6: op = 8'h0E; 7: op = 8'h05;
                  default: op = 8'h06;
               endcase
            end else op = 8'(8'h16 + $urandom_range(0, 233));
            prog[i] = {op, 8'($urandom_range(0, 255))};
         end
         foreach (dmem[i]) dmem[i] = $urandom;
         stray_en = 1;
         do_reset();
         run(400, 0, 3);
         chk("rand_halted_end", halted, mhalt);
         stray_en = 0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
